// File: rtl/jtframe_debug_scan_pkg.sv
// Shared types and constants for the debug selector scanner.
// Holds the FSM state type, the entry count and the entry-to-selector map.
package jtframe_debug_scan_pkg;

  localparam int NENT = 19;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    WAIT,
    CAP,
    DONE
  } state_t;

  // Entry 0 is the base page, 1..16 the 0x4x page, then two single-code pages
  function automatic logic [7:0] sel_code(input logic [4:0] idx);
    logic [4:0] off;
    off = idx - 5'd1;
    if (idx >= 5'd1 && idx <= 5'd16) return 8'h40 | {3'b000, off};
    else if (idx == 5'd17)             return 8'h80;
    else if (idx == 5'd18)             return 8'hC0;
    else                               return 8'h00;
  endfunction

endpackage

// File: rtl/jtframe_debug_scan_buf.sv
// Snapshot buffer: 32x8 captured bytes plus 32x1 change flags.
// Single write port with compare-and-flag, registered read port, bulk flag clear.
module jtframe_debug_scan_buf
  import jtframe_debug_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       clr,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_chg
);

  logic [7:0]  mem [32];
  logic [31:0] chg;
  logic        in_range;

  assign in_range = rd_addr < 5'(NENT);

  // A capture that sees a new byte overrides a simultaneous bulk clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      chg     <= '0;
      rd_data <= '0;
      rd_chg  <= 1'b0;
    end else begin
      rd_data <= in_range ? mem[rd_addr] : 8'h00;
      rd_chg  <= in_range & chg[rd_addr];
      if (clr) chg <= '0;
      if (we) begin
        mem[wr_addr] <= wr_data;
        if (wr_data != mem[wr_addr]) chg[wr_addr] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_debug_scan.sv
// Walks every debug selector code on each vsync rising edge and snapshots the
// byte returned by the target information mux; user selection passes through when idle.
module jtframe_debug_scan
  import jtframe_debug_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vs,
  input  logic [7:0] user_debug,
  output logic [7:0] debug_bus,
  input  logic [7:0] target_info,
  output logic       busy,
  output logic       done,
  output logic       missed,
  input  logic       clr,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_chg
);

  state_t     state, next_state;
  logic [4:0] idx;
  logic [2:0] cnt;
  logic       vs_d;
  logic       vs_rise;
  logic       start;
  logic       last;

  assign vs_rise = vs & ~vs_d;
  assign start   = vs_rise & enable;
  assign last    = (idx == 5'(NENT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Dropping enable ends the scan after the entry currently being captured
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SET;
      SET:     next_state = WAIT;
      WAIT:    if (cnt == 3'd0) next_state = CAP;
      CAP:     next_state = (last || !enable) ? DONE : SET;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Entry 0's code is loaded on the start cycle so the bus never shows user data mid-scan
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d      <= 1'b1;
      idx       <= '0;
      cnt       <= '0;
      debug_bus <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      missed    <= 1'b0;
    end else begin
      vs_d <= vs;
      busy <= (next_state inside {SET, WAIT, CAP});
      done <= (next_state == DONE);
      if (clr)             missed <= 1'b0;
      if (vs_rise && busy) missed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            debug_bus <= sel_code(5'd0);
          end else begin
            debug_bus <= user_debug;
          end
        end
        SET: begin
          debug_bus <= sel_code(idx);
          cnt       <= 3'(SETTLE - 1);
        end
        WAIT: cnt <= cnt - 3'd1;
        CAP:  if (!last && enable) idx <= idx + 5'd1;
        DONE: debug_bus <= user_debug;
        default: ;
      endcase
    end
  end

  jtframe_debug_scan_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (state == CAP),
    .wr_addr (idx),
    .wr_data (target_info),
    .clr     (clr),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_chg  (rd_chg)
  );

endmodule

// File: doc/jtframe_debug_scan.md
Name: jtframe_debug_scan

Overview:
- Drives the 8-bit debug selector into the target information multiplexer and samples the byte it returns.
- On each vertical-sync rising edge it walks all 19 selector codes and captures each returned byte into a snapshot buffer.
- Flags which bytes changed since the previous scan.
- The OSD/debug viewer reads the buffer through a registered read port. When not scanning, the user's own debug selection passes through.

Parameters:
- SETTLE, 2: cycles to wait after debug_bus updates before sampling target_info. Range 1..7.
- NENT, 19: number of scan entries. Fixed by the selector map; not meant to be overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  allow scans to start
- vs  in  1  vertical sync; its rising edge starts a scan
- user_debug  in  8  user selector, forwarded when the block is idle
- debug_bus  out  8  selector driven to the information multiplexer (registered)
- target_info  in  8  byte returned by the multiplexer
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when a scan completes
- missed  out  1  sticky: a vs edge arrived while busy
- clr  in  1  clears all change flags and missed
- rd_addr  in  5  buffer read index
- rd_data  out  8  captured byte at rd_addr, 1-cycle latency
- rd_chg  out  1  change flag at rd_addr, 1-cycle latency

Behaviour:
- Reset values:
  - debug_bus=0, busy=0, done=0, missed=0, rd_data=0, rd_chg=0.
  - All buffer entries = 0 and all change flags = 0.
  - vs edge detector history = 1, so no false start if vs is held high through reset.
  - FSM in IDLE.
- Selector map (entry index -> code):
  - 0 -> 0x00
  - 1..16 -> 0x40 | (idx-1)
  - 17 -> 0x80
  - 18 -> 0xC0
- FSM states: IDLE, SET, WAIT, CAP, DONE.
  - IDLE: debug_bus <= user_debug every cycle. On (vs rising edge & enable): idx<=0, busy<=1, go to SET.
  - SET: debug_bus <= code(idx); counter<=SETTLE-1; go to WAIT.
  - WAIT: decrement counter; when counter==0 go to CAP.
  - CAP:
    - buf[idx] <= target_info.
    - chg[idx] <= (target_info != buf[idx]) | chg[idx].
    - If idx==NENT-1, go to DONE; else idx<=idx+1 and go to SET.
  - DONE: busy<=0, done<=1 for exactly this one cycle, debug_bus<=user_debug, go to IDLE.
- Timing: per entry = 2+SETTLE cycles. Full scan from vs edge to done pulse = NENT*(2+SETTLE)+1 cycles, i.e. 77 at defaults.
- vs rising edge while busy: ignored, missed<=1. The scan is not restarted.
- enable dropped mid-scan: the current entry completes its CAP, then the FSM goes to DONE. done still pulses. Entries not reached keep their old values and flags.
- clr:
  - Clears all chg bits and missed in one cycle.
  - If clr coincides with a CAP that detects a change, the capture wins: that entry's chg=1, all other entries are cleared.
  - If clr coincides with a vs edge while busy, missed ends at 1 (set wins).
- First scan after reset compares against zeroed entries, so any non-zero byte flags as changed.
- Read port:
  - rd_data and rd_chg register buf[rd_addr] and chg[rd_addr] each cycle.
  - A read of the entry being written in CAP returns the old value.
  - rd_addr >= NENT returns rd_data=0, rd_chg=0.
- Reset mid-scan: immediate return to the reset state; the buffer is cleared.

Decomposition:
- Package jtframe_debug_scan_pkg holds:
  - FSM state enum;
  - NENT constant;
  - selector-map function (idx -> code).
- Sub-module jtframe_debug_scan_buf: 32x8 data array plus 32x1 change-flag array.
  - One write port with compare-and-flag logic.
  - One registered read port.
  - Bulk flag clear.

Test Plan:
- Basic scan: model multiplexer returns code^0x5A registered one cycle; assert vs -> done 77 cycles later. rd_addr 0 returns 0x5A, 5 returns 0x1E, 18 returns 0x9A. All rd_chg=1.
- Passthrough: with FSM idle, user_debug=0x47 -> debug_bus=0x47 next cycle. During a scan, debug_bus shows only map codes.
- Change detect: clr, rescan with entry 3's code returning 0x11 instead of the previous value -> only entry 3 has rd_chg=1; the other 18 are 0.
- Overrun: second vs edge 30 cycles into a scan -> missed=1, the scan finishes at cycle 77 unaffected. clr -> missed=0.
- Abort: drop enable during entry 7's WAIT -> entry 7 captured, done pulses, entries 8..18 unchanged, debug_bus returns to user_debug.
- Reset mid-scan: rst at cycle 40 -> busy=0, debug_bus=0, all rd_data=0. A vs already high at reset release does not start a scan.
